// File: rtl/riscv_dpath_divider_pkg.sv
// Shared encodings for the iterative divide/remainder unit: function codes,
// operand width selects and small decode helpers used by the datapath.
package riscv_dpath_divider_pkg;

  localparam logic [1:0] DIV_FN_DIV  = 2'd0;
  localparam logic [1:0] DIV_FN_DIVU = 2'd1;
  localparam logic [1:0] DIV_FN_REM  = 2'd2;
  localparam logic [1:0] DIV_FN_REMU = 2'd3;

  localparam logic DW_32 = 1'b0;
  localparam logic DW_64 = 1'b1;

  // DIV and REM treat their operands as two's complement.
  function automatic logic fn_is_signed(input logic [1:0] fn);
    return (fn == DIV_FN_DIV) || (fn == DIV_FN_REM);
  endfunction

  // REM/REMU return the remainder; DIV/DIVU return the quotient.
  function automatic logic fn_is_rem(input logic [1:0] fn);
    return fn[1];
  endfunction

endpackage

// File: rtl/riscv_dpath_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one, then
// trial-subtract the divisor from the upper half and record the quotient bit.
module riscv_dpath_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] hi;
  logic          fits;

  // The shifted remainder can momentarily need XLEN+1 bits, so the carry-out
  // bit participates in the "divisor fits" decision.
  always_comb begin
    hi       = {rem, quo[XLEN-1]};
    fits     = hi[XLEN] | (hi[XLEN-1:0] >= divisor);
    rem_next = fits ? (hi[XLEN-1:0] - divisor) : hi[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], fits};
  end

endmodule

// File: rtl/riscv_dpath_divider.sv
// Iterative 64-bit integer divide/remainder unit (DIV/DIVU/REM/REMU and the
// 32-bit W forms) with valid/ready request and response ports.  Signed ops
// divide magnitudes and fix signs up afterwards; one quotient bit per cycle.
module riscv_dpath_divider
  import riscv_dpath_divider_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [1:0]       req_fn,
  input  logic             req_dw,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [XLEN-1:0]  req_in1,
  input  logic [XLEN-1:0]  req_in2,
  input  logic             kill,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [2:0] {
    S_READY,
    S_NEG_IN,
    S_BUSY,
    S_NEG_OUT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       fn_q;
  logic             dw_q;
  logic [TAG_W-1:0] tag_q;
  logic             sgn1, sgn2;
  logic             neg_q, neg_r;
  logic [XLEN-1:0]  dvd, dvs;
  logic [XLEN-1:0]  rem, quo;
  logic [XLEN-1:0]  step_rem, step_quo;

  logic             in_signed;
  logic [XLEN-1:0]  in1_x, in2_x;
  logic [XLEN-1:0]  q_fix, r_fix, result;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return -v;
  endfunction

  // Width-adjust the incoming operands so the core always divides XLEN bits.
  always_comb begin
    in_signed = fn_is_signed(req_fn);
    in1_x     = req_in1;
    in2_x     = req_in2;
    if (req_dw == DW_32) begin
      in1_x = in_signed ? sext32(req_in1) : zext32(req_in1);
      in2_x = in_signed ? sext32(req_in2) : zext32(req_in2);
    end
  end

  riscv_dpath_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_next(step_rem),
    .quo_next(step_quo)
  );

  // Sign fix-up and result selection; a zero divisor keeps the all-ones
  // quotient unsigned-looking so DIV x/0 yields -1.
  always_comb begin
    q_fix  = (neg_q && (dvs != '0)) ? negate(quo) : quo;
    r_fix  = neg_r ? negate(rem) : rem;
    result = fn_is_rem(fn_q) ? r_fix : q_fix;
    if (dw_q == DW_32) result = sext32(result);
  end

  // Control FSM with registered handshake outputs and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_READY;
      cnt       <= '0;
      req_rdy   <= 1'b1;
      resp_val  <= 1'b0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else begin
      case (state)
        S_READY: begin
          if (req_val) begin
            state   <= S_NEG_IN;
            req_rdy <= 1'b0;
          end
        end
        S_NEG_IN: begin
          if (kill) begin
            state   <= S_READY;
            req_rdy <= 1'b1;
          end else begin
            state <= S_BUSY;
            cnt   <= CNT_W'(XLEN);
          end
        end
        S_BUSY: begin
          if (kill) begin
            state   <= S_READY;
            req_rdy <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= S_NEG_OUT;
          end
        end
        S_NEG_OUT: begin
          if (kill) begin
            state   <= S_READY;
            req_rdy <= 1'b1;
          end else begin
            state     <= S_DONE;
            resp_val  <= 1'b1;
            resp_data <= result;
            resp_tag  <= tag_q;
          end
        end
        S_DONE: begin
          if (resp_rdy) begin
            state    <= S_READY;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state   <= S_READY;
          req_rdy <= 1'b1;
        end
      endcase
    end
  end

  // Operand/iteration datapath; its contents only matter once the FSM has
  // accepted a request, so it carries no reset.
  always_ff @(posedge clk) begin
    case (state)
      S_READY: begin
        if (req_val) begin
          fn_q  <= req_fn;
          dw_q  <= req_dw;
          tag_q <= req_tag;
          dvd   <= in1_x;
          dvs   <= in2_x;
          sgn1  <= in_signed & in1_x[XLEN-1];
          sgn2  <= in_signed & in2_x[XLEN-1];
        end
      end
      S_NEG_IN: begin
        rem   <= '0;
        quo   <= sgn1 ? negate(dvd) : dvd;
        dvs   <= sgn2 ? negate(dvs) : dvs;
        neg_q <= sgn1 ^ sgn2;
        neg_r <= sgn1;
      end
      S_BUSY: begin
        rem <= step_rem;
        quo <= step_quo;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_dpath_divider.sv
// Directed-vector bench for the iterative divider: latency, signed/unsigned
// results, divide-by-zero, overflow, W forms, backpressure, kill and reset.
module tb_riscv_dpath_divider;

  localparam logic [1:0] FN_DIV  = 2'd0;
  localparam logic [1:0] FN_DIVU = 2'd1;
  localparam logic [1:0] FN_REM  = 2'd2;
  localparam logic [1:0] FN_REMU = 2'd3;
  localparam logic DW32 = 1'b0;
  localparam logic DW64 = 1'b1;
  localparam int   LAT  = 67;

  typedef struct {
    logic [1:0]  fn;
    logic        dw;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [1:0]  req_fn;
  logic        req_dw;
  logic [4:0]  req_tag;
  logic [63:0] req_in1;
  logic [63:0] req_in2;
  logic        kill;
  logic        resp_val;
  logic        resp_rdy;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_dpath_divider #(.XLEN(64), .TAG_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_fn   (req_fn),
    .req_dw   (req_dw),
    .req_tag  (req_tag),
    .req_in1  (req_in1),
    .req_in2  (req_in2),
    .kill     (kill),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_data(resp_data),
    .resp_tag (resp_tag)
  );

  // Present a request and return just after its accept edge.
  task automatic issue(input logic [1:0] fn, input logic dw, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    @(negedge clk);
    req_val = 1'b1; req_fn = fn; req_dw = dw; req_in1 = a; req_in2 = b; req_tag = tag;
    for (int i = 0; i < 100 && !req_rdy; i++) @(negedge clk);
    @(posedge clk);
    #1 req_val = 1'b0;
  endtask

  // Count cycles after the accept edge until resp_val is seen; -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (resp_val) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic complete_resp();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_val = 1'b0; kill = 1'b0; resp_rdy = 1'b1;
    req_fn = FN_DIV; req_dw = DW64; req_tag = '0; req_in1 = '0; req_in2 = '0;
    #1;
    n_checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0 || resp_data !== 64'd0 || resp_tag !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: req_rdy=%b resp_val=%b data=%h tag=%0d, required 1 0 0 0",
               req_rdy, resp_val, resp_data, resp_tag);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    issue(FN_DIVU, DW64, 64'd100, 64'd7, 5'd3);
    wait_resp(lat);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL divu_latency: got %0d cycles, required %0d", lat, LAT);
    end
    n_checks++;
    if (resp_data !== 64'd14 || resp_tag !== 5'd3) begin
      n_fail++; $display("FAIL divu_100_7: data=%h tag=%0d, required 14 tag 3", resp_data, resp_tag);
    end
    complete_resp();
    n_checks++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL divu_handshake: resp_val=%b req_rdy=%b, required 0 1", resp_val, req_rdy);
    end
    issue(FN_REMU, DW64, 64'd100, 64'd7, 5'd4);
    wait_resp(lat);
    n_checks++;
    if (lat !== LAT || resp_data !== 64'd2 || resp_tag !== 5'd4) begin
      n_fail++; $display("FAIL remu_100_7: lat=%0d data=%h tag=%0d, required %0d 2 tag 4",
                         lat, resp_data, resp_tag, LAT);
    end
    complete_resp();
  endtask

  task automatic test_vectors(input string label, input vec_t v[]);
    int lat;
    foreach (v[i]) begin
      issue(v[i].fn, v[i].dw, v[i].a, v[i].b, 5'(i + 8));
      wait_resp(lat);
      n_checks++;
      if (lat !== LAT || resp_data !== v[i].exp || resp_tag !== 5'(i + 8)) begin
        n_fail++;
        $display("FAIL %s[%0d]: lat=%0d data=%h tag=%0d, required lat %0d data %h tag %0d",
                 label, i, lat, resp_data, resp_tag, LAT, v[i].exp, i + 8);
      end
      complete_resp();
    end
  endtask

  task automatic test_signed();
    vec_t v[] = '{
      '{FN_DIV, DW64, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD},
      '{FN_REM, DW64, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF},
      '{FN_REM, DW64, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1}
    };
    test_vectors("signed", v);
  endtask

  task automatic test_div_zero();
    vec_t v[] = '{
      '{FN_DIV,  DW64, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF},
      '{FN_REM,  DW64, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB},
      '{FN_DIVU, DW64, 64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF},
      '{FN_REM,  DW32, 64'h0000_0000_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB}
    };
    test_vectors("div_zero", v);
  endtask

  task automatic test_overflow();
    vec_t v[] = '{
      '{FN_DIV, DW64, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000},
      '{FN_REM, DW64, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0},
      '{FN_DIV, DW32, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000},
      '{FN_REM, DW32, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0}
    };
    test_vectors("overflow", v);
  endtask

  task automatic test_word();
    vec_t v[] = '{
      '{FN_DIVU, DW32, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_0000_0002, 64'h0000_0000_7FFF_FFFF},
      '{FN_REMU, DW32, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_0000_0002, 64'd0}
    };
    test_vectors("word", v);
  endtask

  task automatic test_backpressure();
    int lat;
    resp_rdy = 1'b0;
    issue(FN_DIVU, DW64, 64'd1000, 64'd10, 5'd7);
    wait_resp(lat);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (resp_val !== 1'b1 || resp_data !== 64'd100 || resp_tag !== 5'd7 || req_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: val=%b data=%h tag=%0d rdy=%b, required 1 100 7 0",
                 i, resp_val, resp_data, resp_tag, req_rdy);
      end
      @(negedge clk);
    end
    resp_rdy = 1'b1;
    complete_resp();
    n_checks++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_release: val=%b rdy=%b, required 0 1", resp_val, req_rdy);
    end
  endtask

  task automatic test_kill();
    int lat;
    int seen;
    issue(FN_DIVU, DW64, 64'd100, 64'd7, 5'd1);
    repeat (21) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    n_checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      n_fail++; $display("FAIL kill_state: rdy=%b val=%b, required 1 0", req_rdy, resp_val);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_val) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL kill_no_resp: resp_val high %0d cycles, required 0", seen);
    end
    issue(FN_DIVU, DW64, 64'd200, 64'd9, 5'd2);
    wait_resp(lat);
    n_checks++;
    if (lat !== LAT || resp_data !== 64'd22 || resp_tag !== 5'd2) begin
      n_fail++; $display("FAIL kill_followup: lat=%0d data=%h tag=%0d, required %0d 22 2",
                         lat, resp_data, resp_tag, LAT);
    end
    complete_resp();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    issue(FN_DIV, DW64, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd5);
    repeat (31) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1 || resp_data !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid: val=%b rdy=%b data=%h, required 0 1 0",
                         resp_val, req_rdy, resp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_val) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_resp: resp_val high %0d cycles, required 0", seen);
    end
    issue(FN_REM, DW64, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd6);
    wait_resp(lat);
    n_checks++;
    if (lat !== LAT || resp_data !== 64'hFFFF_FFFF_FFFF_FFFE || resp_tag !== 5'd6) begin
      n_fail++; $display("FAIL reset_mid_followup: lat=%0d data=%h tag=%0d, required %0d fffffffffffffffe 6",
                         lat, resp_data, resp_tag, LAT);
    end
    complete_resp();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_word();
    test_backpressure();
    test_kill();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
